// File: rtl/ram_loader_pkg.sv
// Shared definitions for the program-RAM port arbiter: FSM encoding,
// default FIFO depth and the byte-to-word address width derivation.
package ram_loader_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_e;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_ADDR_WIDTH = 15;
  localparam int BYTE_ADDR_BITS = 2;

  // Word address width: the RAM is 32 bits wide, so the two byte-select
  // bits of the byte address are not part of the word address.
  function automatic int word_aw(input int addr_width);
    return addr_width - BYTE_ADDR_BITS;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO with occupancy count. DEPTH must be a power of
// two so the read/write pointers wrap naturally. A push while full is
// only legal together with a pop in the same cycle; the caller decides.
module word_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_r;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == '0);

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port program RAM arbiter: loader word writes (buffered, never
// back-pressured) versus CPU bus accesses (stalled via busAck). The port
// grant is combinational from registered state so a granted CPU write
// completes in its own cycle and a read acks one cycle later.
module ram_port_arbiter
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                            HCLK,
  input  logic                            resetHW,
  input  logic                            ROMload,
  input  logic                            wNow,
  input  logic [word_aw(ADDR_WIDTH)-1:0]  wAddr,
  input  logic [31:0]                     wData,
  input  logic                            busReq,
  input  logic                            busWrite,
  input  logic [word_aw(ADDR_WIDTH)-1:0]  busAddr,
  input  logic [31:0]                     busWData,
  input  logic [3:0]                      busByteEn,
  output logic                            busAck,
  output logic [31:0]                     busRData,
  output logic                            ramEn,
  output logic [3:0]                      ramWE,
  output logic [word_aw(ADDR_WIDTH)-1:0]  ramAddr,
  output logic [31:0]                     ramWData,
  input  logic [31:0]                     ramRData,
  output logic                            loadDone,
  output logic                            loadOverflow,
  output logic [word_aw(ADDR_WIDTH):0]    loadWords
);

  localparam int AW = word_aw(ADDR_WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = 32 + AW;
  // At this occupancy the loader takes the port even against a CPU request,
  // so the FIFO always keeps one free slot for the next unstoppable strobe.
  localparam logic [CW-1:0] FORCE_LEVEL = CW'(FIFO_DEPTH - 1);

  arb_state_e      state_r;
  logic            rom_q_r;
  logic            pend_r;
  logic [AW-1:0]   addr_r;
  logic [31:0]     wdata_r;
  logic [AW:0]     load_words_r;
  logic            overflow_r;

  logic [FW-1:0]   fifo_rdata;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            drop;
  logic            cpu_grant;
  logic            loader_grant;
  logic            rom_rise;
  logic            rom_fall;
  logic            pend_eff;
  logic            empty_after_pop;

  word_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (resetHW),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({wAddr, wData}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Port grant: CPU first unless loading or the FIFO is nearly full; loader otherwise.
  always_comb begin
    cpu_grant    = 1'b0;
    loader_grant = 1'b0;
    if (resetHW) begin
      cpu_grant    = 1'b0;
      loader_grant = 1'b0;
    end else begin
      cpu_grant    = busReq && (state_r == IDLE) && !ROMload && (fifo_count < FORCE_LEVEL);
      loader_grant = !fifo_empty && !cpu_grant;
    end
  end

  // FIFO control: a strobe into a full FIFO is accepted only if a pop frees a slot.
  always_comb begin
    fifo_pop  = loader_grant;
    fifo_push = 1'b0;
    drop      = 1'b0;
    if (resetHW) begin
      fifo_push = 1'b0;
      drop      = 1'b0;
    end else begin
      fifo_push = wNow && (!fifo_full || fifo_pop);
      drop      = wNow && fifo_full && !fifo_pop;
    end
  end

  // Load-completion detection on ROMload edges and FIFO drain state.
  always_comb begin
    rom_rise        = ROMload && !rom_q_r;
    rom_fall        = !ROMload && rom_q_r;
    pend_eff        = pend_r || rom_fall;
    empty_after_pop = (fifo_count == {{(CW-1){1'b0}}, fifo_pop});
    loadDone        = 1'b0;
    if (resetHW) begin
      loadDone = 1'b0;
    end else begin
      loadDone = pend_eff && !rom_rise && empty_after_pop;
    end
  end

  // RAM port and bus response muxing; address/data hold their last values when idle.
  always_comb begin
    ramEn    = 1'b0;
    ramWE    = 4'h0;
    ramAddr  = addr_r;
    ramWData = wdata_r;
    busAck   = 1'b0;
    busRData = 32'h0;
    if (resetHW) begin
      ramAddr  = '0;
      ramWData = 32'h0;
    end else if (cpu_grant) begin
      ramEn    = 1'b1;
      ramAddr  = busAddr;
      ramWE    = busWrite ? busByteEn : 4'h0;
      ramWData = busWrite ? busWData : wdata_r;
      busAck   = busWrite;
    end else if (loader_grant) begin
      ramEn    = 1'b1;
      ramWE    = 4'hF;
      ramAddr  = fifo_rdata[FW-1:32];
      ramWData = fifo_rdata[31:0];
    end else begin
      ramEn = 1'b0;
    end
    if (!resetHW && (state_r == RD_WAIT)) begin
      busAck   = 1'b1;
      busRData = ramRData;
    end else begin
      busRData = 32'h0;
    end
  end

  // Read FSM: a granted CPU read waits exactly one cycle for RAM data.
  always_ff @(posedge HCLK) begin
    if (resetHW) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    state_r <= (cpu_grant && !busWrite) ? RD_WAIT : IDLE;
        RD_WAIT: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Held port values, load counters, overflow flag and load-done pending bit.
  always_ff @(posedge HCLK) begin
    if (resetHW) begin
      rom_q_r      <= 1'b0;
      pend_r       <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= 32'h0;
      load_words_r <= '0;
      overflow_r   <= 1'b0;
    end else begin
      rom_q_r <= ROMload;
      if (rom_rise || loadDone) begin
        pend_r <= 1'b0;
      end else begin
        pend_r <= pend_eff;
      end
      if (ramEn) begin
        addr_r <= ramAddr;
      end
      if (ramWE != 4'h0) begin
        wdata_r <= ramWData;
      end
      if (fifo_pop) begin
        load_words_r <= load_words_r + (AW+1)'(1);
      end
      if (drop) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign loadOverflow = overflow_r;
  assign loadWords    = load_words_r;

endmodule
